// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with in-order instruction queue; optional FETCH_QUEUE_BYPASS_EN
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h1eceb000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [3:0]         rmask_q, rmask_d;
    logic               run_q, run_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]        qpc_q   [QUEUE_DEPTH];
    logic [31:0]        qinst_q [QUEUE_DEPTH];

    logic               head_valid;
    logic               pop;
    logic               push;
    logic               bypass;
    logic               wait_resp;
    logic               may_issue;
    logic               credit_after;
    logic [31:0]        redirect_pc_a;
    logic               unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];
    assign imem_addr  = pc_q;
    assign imem_rmask = rmask_q;

    // Queue handshake, credit and bypass qualification
    always_comb begin
        redirect_pc_a = {redirect_pc[31:2], 2'b00};
        head_valid    = (count_q != '0);
        pop           = head_valid && out_ready;
        wait_resp     = (state_q == WAIT) && imem_resp;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass        = wait_resp && !redirect && !head_valid && out_ready;
`else
        bypass        = 1'b0;
`endif
        push          = wait_resp && !redirect && !bypass;
        // run_q holds IDLE for one cycle after reset release; a same-cycle pop is not credit
        may_issue     = run_q && (count_q < DEPTH_C);
        credit_after  = (count_q + CNT_W'(push)) < DEPTH_C;
    end

    // Fetch FSM next state, next pc and registered read mask
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        run_d   = 1'b1;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d = redirect_pc_a;
                end else if (may_issue) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    pc_d    = redirect_pc_a;
                    state_d = DRAIN;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_d    = redirect_pc_a;
                    state_d = imem_resp ? IDLE : DRAIN;
                end else if (imem_resp) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = credit_after ? REQ : IDLE;
                end
            end
            DRAIN: begin
                // the abandoned request still owes a response; swallow it before issuing again
                if (redirect) begin
                    pc_d = redirect_pc_a;
                end
                if (imem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rmask_d = (state_d == REQ) ? 4'hF : 4'h0;
    end

    // Queue pointer and occupancy update; redirect flushes after any coincident pop
    always_comb begin
        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
        end
    end

    // Consumer-facing head of queue, or the live response when bypassing
    always_comb begin
        out_valid = head_valid;
        out_pc    = head_valid ? qpc_q[rd_ptr_q]   : 32'h0;
        out_inst  = head_valid ? qinst_q[rd_ptr_q] : 32'h0;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (bypass) begin
            out_valid = 1'b1;
            out_pc    = pc_q;
            out_inst  = imem_rdata;
        end
`endif
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            rmask_q  <= 4'h0;
            run_q    <= 1'b0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rmask_q  <= rmask_d;
            run_q    <= run_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Queue storage; contents are only meaningful below count_q so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            qpc_q[wr_ptr_q]   <= pc_q;
            qinst_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h1eceb000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_resp = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    int          errors = 0;
    int          checks = 0;

    int          mem_delay = 5;
    bit          keep_pending = 1'b0;
    bit          pending = 1'b0;
    int          remaining = 0;
    int          req_cnt = 0;
    logic [31:0] mem_addr = 32'h0;

    logic [31:0] got_pc[$];
    logic [31:0] got_inst[$];
    int          rd_idx = 0;

    fetch_unit #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rmask (imem_rmask),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_inst   (out_inst)
    );

    always #5 clk = ~clk;

    // Memory: answers a request after mem_delay cycles with {addr[15:0], 16'hc0de}
    always @(negedge clk) begin
        imem_resp = 1'b0;
        if (!rst && !keep_pending) begin
            pending = 1'b0;
        end else if (pending) begin
            remaining = remaining - 1;
            if (remaining == 0) begin
                imem_resp  = 1'b1;
                imem_rdata = {mem_addr[15:0], 16'hc0de};
                pending    = 1'b0;
            end
        end
        if (imem_rmask == 4'hF) begin
            pending   = 1'b1;
            remaining = mem_delay;
            mem_addr  = imem_addr;
            req_cnt   = req_cnt + 1;
        end
    end

    // Consumer log
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            got_pc.push_back(out_pc);
            got_inst.push_back(out_inst);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rmask(input string tag);
        int n = 0;
        while (imem_rmask !== 4'hF && n < 60) begin
            cyc(1);
            n++;
        end
        chk(tag, {28'h0, imem_rmask}, 32'hF);
    endtask

    task automatic wait_resp_neg(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (imem_resp !== 1'b1 && n < 60);
        chk(tag, {31'h0, imem_resp}, 32'h1);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        int n = 0;
        while (got_pc.size() <= rd_idx && n < 80) begin
            cyc(1);
            n++;
        end
        chk({tag, "_avail"}, (got_pc.size() > rd_idx) ? 32'h1 : 32'h0, 32'h1);
        if (got_pc.size() > rd_idx) begin
            chk({tag, "_pc"}, got_pc[rd_idx], pc);
            chk({tag, "_inst"}, got_inst[rd_idx], inst);
            rd_idx++;
        end
    endtask

    initial begin
        int base;
        int r0;
        int n;

        // reset state
        cyc(3);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_rmask", {28'h0, imem_rmask}, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_addr", imem_addr, RESET_PC);

        // release: IDLE one cycle, REQ in the second cycle, delay 5 -> push visible 6 cycles later
        @(negedge clk);
        rst = 1'b1;
        cyc(1);
        chk("c1_rmask", {28'h0, imem_rmask}, 32'h0);
        cyc(1);
        chk("c2_rmask", {28'h0, imem_rmask}, 32'hF);
        chk("c2_addr", imem_addr, 32'h1eceb000);
        cyc(1);
        chk("c3_rmask", {28'h0, imem_rmask}, 32'h0);
        cyc(4);
        chk("c7_valid", {31'h0, out_valid}, 32'h0);
        cyc(1);
        chk("c8_valid", {31'h0, out_valid}, 32'h1);
        chk("c8_out_pc", out_pc, 32'h1eceb000);
        chk("c8_out_inst", out_inst, 32'hb000c0de);
        chk("c8_rmask", {28'h0, imem_rmask}, 32'hF);
        chk("c8_addr", imem_addr, 32'h1eceb004);
        expect_out("o0", 32'h1eceb000, 32'hb000c0de);
        expect_out("o1", 32'h1eceb004, 32'hb004c0de);
        expect_out("o2", 32'h1eceb008, 32'hb008c0de);

        // backpressure: fill to exactly 4 entries, then drain
        mem_delay = 1;
        out_ready = 1'b0;
        cyc(20);
        r0 = req_cnt;
        cyc(5);
        chk("full_no_req", req_cnt, r0);
        chk("full_rmask", {28'h0, imem_rmask}, 32'h0);
        chk("full_valid", {31'h0, out_valid}, 32'h1);
        mem_delay = 5;
        base = got_pc.size();
        out_ready = 1'b1;
        cyc(4);
        chk("drain_count", got_pc.size(), base + 4);
        chk("drain_gap_valid", {31'h0, out_valid}, 32'h0);
        n = 0;
        while (got_pc.size() < base + 5 && n < 40) begin
            cyc(1);
            n++;
        end
        chk("drain_fifth", got_pc.size(), base + 5);
        for (int i = 0; i < got_pc.size(); i++) begin
            logic [31:0] epc;
            epc = RESET_PC + 32'(4 * i);
            chk("seq_pc", got_pc[i], epc);
            chk("seq_inst", got_inst[i], {epc[15:0], 16'hc0de});
        end

        // redirect during WAIT with a queued entry
        out_ready = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            cyc(1);
            n++;
        end
        wait_rmask("r1_req");
        cyc(1);
        chk("r1_valid_before", {31'h0, out_valid}, 32'h1);
        redirect    = 1'b1;
        redirect_pc = 32'h1eceb103;
        cyc(1);
        redirect = 1'b0;
        chk("r1_valid_after", {31'h0, out_valid}, 32'h0);
        chk("r1_drain_rmask", {28'h0, imem_rmask}, 32'h0);
        rd_idx = got_pc.size();
        out_ready = 1'b1;
        expect_out("r1_first", 32'h1eceb100, 32'hb100c0de);
        expect_out("r1_second", 32'h1eceb104, 32'hb104c0de);

        // redirect coincident with a response
        wait_resp_neg("r2_resp");
        redirect    = 1'b1;
        redirect_pc = 32'h1eceb100;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        rd_idx = got_pc.size();
        chk("r2_no_push", {31'h0, out_valid}, 32'h0);
        chk("r2_idle_rmask", {28'h0, imem_rmask}, 32'h0);
        cyc(1);
        chk("r2_req_rmask", {28'h0, imem_rmask}, 32'hF);
        chk("r2_req_addr", imem_addr, 32'h1eceb100);
        expect_out("r2_first", 32'h1eceb100, 32'hb100c0de);

        // address wrap at the top of the address space
        wait_resp_neg("w_resp");
        redirect    = 1'b1;
        redirect_pc = 32'hFFFFFFFC;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        rd_idx = got_pc.size();
        cyc(1);
        chk("w_req_addr", imem_addr, 32'hFFFFFFFC);
        cyc(1);
        wait_rmask("w_req2");
        chk("w_wrap_addr", imem_addr, 32'h00000000);
        expect_out("w_top", 32'hFFFFFFFC, 32'hfffcc0de);
        expect_out("w_zero", 32'h00000000, 32'h0000c0de);

        // reset while in WAIT; the old response lands while IDLE after release
        wait_rmask("x_req");
        cyc(1);
        keep_pending = 1'b1;
        rst = 1'b0;
        #1;
        chk("x_rmask", {28'h0, imem_rmask}, 32'h0);
        chk("x_valid", {31'h0, out_valid}, 32'h0);
        chk("x_addr", imem_addr, RESET_PC);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("x_c1_rmask", {28'h0, imem_rmask}, 32'h0);
        cyc(1);
        chk("x_c2_rmask", {28'h0, imem_rmask}, 32'hF);
        chk("x_c2_addr", imem_addr, RESET_PC);
        chk("x_stale_dropped", {31'h0, out_valid}, 32'h0);
        keep_pending = 1'b0;
        rd_idx = got_pc.size();
        expect_out("x_first", RESET_PC, 32'hb000c0de);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
